// File: rtl/sr_run_ctrl_pkg.sv
// Shared types and constants for the sr_cpu run-control sequencer.
//   cmd_op_t     : debug host command opcodes (3-bit encoding on cmd_op)
//   state_t      : sequencer state
//   halt_cause_t : reason reported on halt_cause after the last halt
package sr_run_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DataW    = 32;

  typedef enum logic [2:0] {
    CmdNop     = 3'd0,
    CmdRun     = 3'd1,
    CmdHalt    = 3'd2,
    CmdStep    = 3'd3,
    CmdSetBp   = 3'd4,
    CmdClrBp   = 3'd5,
    CmdReadReg = 3'd6,
    CmdReadCnt = 3'd7
  } cmd_op_t;

  typedef enum logic [1:0] {
    StHalted   = 2'd0,
    StRunning  = 2'd1,
    StStepping = 2'd2,
    StReading  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CauseCmd     = 2'd0,
    CauseBp      = 2'd1,
    CauseInvalid = 2'd2,
    CauseStep    = 2'd3
  } halt_cause_t;

  // True when a breakpoint index addresses an implemented comparator.
  function automatic logic bp_sel_ok(logic [RegAddrW-1:0] sel, int unsigned num_bp);
    return 32'(sel) < num_bp;
  endfunction

endpackage

// File: rtl/sr_run_ctrl_bp.sv
// PC breakpoint bank for the run-control sequencer.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset, disables every comparator
//   set_i     : load pc_i into comparator sel_i and enable it
//   clr_i     : disable comparator sel_i
//   sel_i     : comparator index (caller guarantees it is in range)
//   pc_i      : breakpoint address to load
//   cmp_pc_i  : current CPU PC to compare against
//   hit_o     : any enabled comparator matches cmp_pc_i
module sr_run_ctrl_bp
  import sr_run_ctrl_pkg::*;
#(
  parameter int unsigned NumBp = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_i,
  input  logic                clr_i,
  input  logic [RegAddrW-1:0] sel_i,
  input  logic [DataW-1:0]    pc_i,
  input  logic [DataW-1:0]    cmp_pc_i,
  output logic                hit_o
);

  logic [DataW-1:0] pc_q [NumBp];
  logic [NumBp-1:0] en_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q <= '0;
      for (int unsigned i = 0; i < NumBp; i++) begin
        pc_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumBp; i++) begin
        if (sel_i == RegAddrW'(i)) begin
          if (set_i) begin
            pc_q[i] <= pc_i;
            en_q[i] <= 1'b1;
          end else if (clr_i) begin
            en_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    hit_o = 1'b0;
    for (int unsigned i = 0; i < NumBp; i++) begin
      if (en_q[i] && (pc_q[i] == cmp_pc_i)) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_run_ctrl.sv
// Run-control sequencer for sr_cpu: run / halt / single-step, PC breakpoints,
// halt on invalid instruction, debug register reads and an executed-cycle counter.
//   clk, rst        : clock, synchronous active-low reset
//   cmd_valid/ready : debug host command handshake (accept on valid && ready)
//   cmd_op/sel/arg  : opcode, breakpoint index or register address, PC or step count
//   rsp_valid       : one-cycle response pulse per accepted command
//   rsp_err/data    : response status and read data, valid with rsp_valid
//   cpu_en          : CPU executes one instruction this cycle
//   cpu_invalid     : CPU reports an invalid instruction at the current PC
//   dbg_addr/data   : CPU debug register port (address 0 reads the PC)
//   halted          : sequencer is in the halted state
//   halt_cause      : cause of the most recent halt
module sr_run_ctrl
  import sr_run_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BP        = 2,
  parameter int unsigned STEP_W        = 16,
  parameter bit          START_RUNNING = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [RegAddrW-1:0] cmd_sel,
  input  logic [DataW-1:0]    cmd_arg,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DataW-1:0]    rsp_data,
  output logic                cpu_en,
  input  logic                cpu_invalid,
  output logic [RegAddrW-1:0] dbg_addr,
  input  logic [DataW-1:0]    dbg_data,
  output logic                halted,
  output logic [1:0]          halt_cause
);

  state_t                state_q, state_d;
  halt_cause_t           cause_q, cause_d;
  logic                  skip_bp_q, skip_bp_d;
  logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
  logic [RegAddrW-1:0]   read_sel_q, read_sel_d;
  logic [DataW-1:0]      cycle_cnt_q, cycle_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DataW-1:0]      rsp_data_q, rsp_data_d;

  cmd_op_t               op;
  logic                  cmd_acc;
  logic                  sel_ok;
  logic                  bp_hit;
  logic                  bp_hit_eff;
  logic                  bp_set;
  logic                  bp_clr;
  logic                  auto_halt;
  logic [STEP_W-1:0]     step_n;

  assign op        = cmd_op_t'(cmd_op);
  assign cmd_ready = (state_q != StStepping) && (state_q != StReading);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign sel_ok    = bp_sel_ok(cmd_sel, NUM_BP);
  // The PC on which RUN was issued must execute once even if it has a breakpoint.
  assign bp_hit_eff = bp_hit && !skip_bp_q;
  assign step_n    = (cmd_arg[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_arg[STEP_W-1:0];

  // dbg_data only carries the PC while dbg_addr is 0, i.e. outside StReading.
  assign dbg_addr  = (state_q == StReading) ? read_sel_q : '0;

  assign halted     = (state_q == StHalted);
  assign halt_cause = cause_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;

  sr_run_ctrl_bp #(
    .NumBp (NUM_BP)
  ) u_bp (
    .clk_i    (clk),
    .rst_ni   (rst),
    .set_i    (bp_set),
    .clr_i    (bp_clr),
    .sel_i    (cmd_sel),
    .pc_i     (cmd_arg),
    .cmp_pc_i (dbg_data),
    .hit_o    (bp_hit)
  );

  always_comb begin
    cpu_en = 1'b0;
    unique case (state_q)
      StRunning:  cpu_en = !bp_hit_eff && !cpu_invalid;
      StStepping: cpu_en = !cpu_invalid;
      default:    cpu_en = 1'b0;
    endcase
  end

  assign cycle_cnt_d = cycle_cnt_q + DataW'(cpu_en);

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    skip_bp_d   = skip_bp_q;
    step_cnt_d  = step_cnt_q;
    read_sel_d  = read_sel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    bp_set      = 1'b0;
    bp_clr      = 1'b0;
    auto_halt   = 1'b0;

    // Autonomous progress of the current state.
    unique case (state_q)
      StRunning: begin
        if (bp_hit_eff) begin
          state_d   = StHalted;
          cause_d   = CauseBp;
          auto_halt = 1'b1;
        end else if (cpu_invalid) begin
          state_d   = StHalted;
          cause_d   = CauseInvalid;
          auto_halt = 1'b1;
        end else begin
          skip_bp_d = 1'b0;
        end
      end
      StStepping: begin
        // Completes the STEP command: its response is issued here.
        if (cpu_invalid) begin
          state_d     = StHalted;
          cause_d     = CauseInvalid;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (step_cnt_q == STEP_W'(1)) begin
          state_d     = StHalted;
          cause_d     = CauseStep;
          rsp_valid_d = 1'b1;
        end else begin
          step_cnt_d  = step_cnt_q - STEP_W'(1);
        end
      end
      StReading: begin
        state_d     = StHalted;
        rsp_valid_d = 1'b1;
        rsp_data_d  = dbg_data;
      end
      default: ;
    endcase

    // Commands are only accepted in StHalted or StRunning.
    if (cmd_acc) begin
      rsp_valid_d = 1'b1;
      unique case (op)
        CmdNop: ;
        CmdRun: begin
          if (state_q == StHalted) begin
            state_d   = StRunning;
            skip_bp_d = 1'b1;
          end
        end
        CmdHalt: begin
          state_d = StHalted;
          if (!auto_halt) begin
            cause_d = CauseCmd;
          end
        end
        CmdStep: begin
          if (state_q == StHalted) begin
            state_d     = StStepping;
            step_cnt_d  = step_n;
            rsp_valid_d = 1'b0;
          end else begin
            rsp_err_d   = 1'b1;
          end
        end
        CmdSetBp: begin
          if (sel_ok) begin
            bp_set    = 1'b1;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        CmdClrBp: begin
          if (sel_ok) begin
            bp_clr    = 1'b1;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        CmdReadReg: begin
          if (state_q == StHalted) begin
            state_d     = StReading;
            read_sel_d  = cmd_sel;
            rsp_valid_d = 1'b0;
          end else begin
            rsp_err_d   = 1'b1;
          end
        end
        CmdReadCnt: begin
          rsp_data_d = cycle_cnt_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= START_RUNNING ? StRunning : StHalted;
      cause_q     <= CauseCmd;
      skip_bp_q   <= 1'b0;
      step_cnt_q  <= '0;
      read_sel_q  <= '0;
      cycle_cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      skip_bp_q   <= skip_bp_d;
      step_cnt_q  <= step_cnt_d;
      read_sel_q  <= read_sel_d;
      cycle_cnt_q <= cycle_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_sr_run_ctrl.sv
`timescale 1ns/1ps
module tb_sr_run_ctrl;
  import sr_run_ctrl_pkg::*;

  localparam int unsigned NUM_BP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [4:0]  cmd_sel = 5'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        cpu_en, cpu_invalid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        halted;
  logic [1:0]  halt_cause;

  // Minimal sr_cpu model: PC advances by 4 per enabled cycle, x[i] reads 0x1000_0000 | i.
  logic [31:0] pc = 32'd0;
  int          en_cnt = 0;
  logic        inv_on = 1'b0;
  logic [31:0] inv_pc = 32'd0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    string       name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sr_run_ctrl #(
    .NUM_BP        (NUM_BP),
    .STEP_W        (16),
    .START_RUNNING (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_sel     (cmd_sel),
    .cmd_arg     (cmd_arg),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_data    (rsp_data),
    .cpu_en      (cpu_en),
    .cpu_invalid (cpu_invalid),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .halted      (halted),
    .halt_cause  (halt_cause)
  );

  assign cpu_invalid = inv_on && (pc == inv_pc);
  assign dbg_data    = (dbg_addr == 5'd0) ? pc : (32'h1000_0000 | 32'(dbg_addr));

  always @(posedge clk) begin
    if (!rst) begin
      pc <= 32'd0;
    end else if (cpu_en) begin
      pc     <= pc + 32'd4;
      en_cnt <= en_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got err=%0d data=0x%08h expected no response",
                 rsp_err, rsp_data);
      end else begin
        e = sb.pop_front();
        check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
        check({e.name, "_data"}, rsp_data, e.data);
      end
    end
  end

  task automatic expect_rsp(input string name, input logic err, input logic [31:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    e.name = name;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input cmd_op_t op, input logic [4:0] sel, input logic [31:0] arg);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_arg   = arg;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_ready_timeout: got ready=0 expected ready=1 within 50 cycles");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!halted && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_b(name, halted, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pending_rsp_count", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int e0;
    int n;
    @(negedge clk);

    // 1: reset state, free run for 10 enabled cycles, counter readback
    do_reset();
    check_b("rst_halted", halted, 1'b1);
    check("rst_cause", 32'(halt_cause), 32'(CauseCmd));
    check_b("rst_rsp_valid", rsp_valid, 1'b0);
    check_b("rst_cmd_ready", cmd_ready, 1'b1);
    check_b("rst_cpu_en", cpu_en, 1'b0);
    check("rst_dbg_addr", 32'(dbg_addr), 32'd0);
    expect_rsp("t1_run", 1'b0, 32'd0);
    send(CmdRun, 5'd0, 32'd0);
    check_b("t1_running", halted, 1'b0);
    repeat (9) @(negedge clk);
    expect_rsp("t1_halt", 1'b0, 32'd0);
    send(CmdHalt, 5'd0, 32'd0);
    check_b("t1_halted", halted, 1'b1);
    check("t1_cause", 32'(halt_cause), 32'(CauseCmd));
    check("t1_pc", pc, 32'd40);
    expect_rsp("t1_cnt", 1'b0, 32'd10);
    send(CmdReadCnt, 5'd0, 32'd0);
    drain();

    // 2: breakpoint halt, then resume past it
    do_reset();
    expect_rsp("t2_setbp", 1'b0, 32'd0);
    send(CmdSetBp, 5'd0, 32'h10);
    expect_rsp("t2_run", 1'b0, 32'd0);
    send(CmdRun, 5'd0, 32'd0);
    wait_halted("t2_bp_halt");
    check("t2_pc", pc, 32'h10);
    check("t2_cause", 32'(halt_cause), 32'(CauseBp));
    expect_rsp("t2_run2", 1'b0, 32'd0);
    send(CmdRun, 5'd0, 32'd0);
    check_b("t2_exec_bp_insn", cpu_en, 1'b1);
    @(negedge clk);
    check("t2_pc_past_bp", pc, 32'h14);
    check_b("t2_still_running", halted, 1'b0);
    expect_rsp("t2_halt", 1'b0, 32'd0);
    send(CmdHalt, 5'd0, 32'd0);
    drain();

    // 3: single-step counts, including n==0 treated as 1
    do_reset();
    e0 = en_cnt;
    expect_rsp("t3_step3", 1'b0, 32'd0);
    send(CmdStep, 5'd0, 32'd3);
    check_b("t3_busy_not_ready", cmd_ready, 1'b0);
    wait_halted("t3_step3_done");
    check_b("t3_rsp_with_halt", rsp_valid, 1'b1);
    check("t3_pc", pc, 32'hC);
    check("t3_pulses", 32'(en_cnt - e0), 32'd3);
    check("t3_cause", 32'(halt_cause), 32'(CauseStep));
    e0 = en_cnt;
    expect_rsp("t3_step0", 1'b0, 32'd0);
    send(CmdStep, 5'd0, 32'd0);
    wait_halted("t3_step0_done");
    check("t3_step0_pulses", 32'(en_cnt - e0), 32'd1);
    check("t3_step0_pc", pc, 32'h10);
    drain();

    // 4: invalid instruction while running and while stepping
    do_reset();
    inv_on = 1'b1;
    inv_pc = 32'h8;
    expect_rsp("t4_run", 1'b0, 32'd0);
    send(CmdRun, 5'd0, 32'd0);
    n = 0;
    while (pc != 32'h8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach_pc8", pc, 32'h8);
    check_b("t4_cpu_en_low", cpu_en, 1'b0);
    @(negedge clk);
    check_b("t4_halted", halted, 1'b1);
    check("t4_cause", 32'(halt_cause), 32'(CauseInvalid));
    check("t4_pc_held", pc, 32'h8);
    drain();
    do_reset();
    e0 = en_cnt;
    expect_rsp("t4_step_inv", 1'b1, 32'd0);
    send(CmdStep, 5'd0, 32'd5);
    wait_halted("t4_step_halt");
    check("t4_step_pc", pc, 32'h8);
    check("t4_step_pulses", 32'(en_cnt - e0), 32'd2);
    check("t4_step_cause", 32'(halt_cause), 32'(CauseInvalid));
    drain();
    inv_on = 1'b0;

    // 5: register reads, error responses
    do_reset();
    expect_rsp("t5_step2", 1'b0, 32'd0);
    send(CmdStep, 5'd0, 32'd2);
    wait_halted("t5_step2_halt");
    expect_rsp("t5_rd_x5", 1'b0, 32'h1000_0005);
    send(CmdReadReg, 5'd5, 32'd0);
    check("t5_dbg_addr", 32'(dbg_addr), 32'd5);
    check_b("t5_rd_not_ready", cmd_ready, 1'b0);
    check_b("t5_rd_no_early_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    check_b("t5_rd_rsp_at_2", rsp_valid, 1'b1);
    check("t5_dbg_addr_back", 32'(dbg_addr), 32'd0);
    expect_rsp("t5_rd_pc", 1'b0, 32'h8);
    send(CmdReadReg, 5'd0, 32'd0);
    @(negedge clk);
    expect_rsp("t5_run", 1'b0, 32'd0);
    send(CmdRun, 5'd0, 32'd0);
    expect_rsp("t5_rd_running", 1'b1, 32'd0);
    send(CmdReadReg, 5'd5, 32'd0);
    expect_rsp("t5_step_running", 1'b1, 32'd0);
    send(CmdStep, 5'd0, 32'd1);
    expect_rsp("t5_run_running", 1'b0, 32'd0);
    send(CmdRun, 5'd0, 32'd0);
    check_b("t5_still_running", halted, 1'b0);
    expect_rsp("t5_halt", 1'b0, 32'd0);
    send(CmdHalt, 5'd0, 32'd0);
    expect_rsp("t5_setbp_oob", 1'b1, 32'd0);
    send(CmdSetBp, 5'(NUM_BP), 32'h20);
    expect_rsp("t5_clrbp_oob", 1'b1, 32'd0);
    send(CmdClrBp, 5'(NUM_BP), 32'd0);
    expect_rsp("t5_nop", 1'b0, 32'd0);
    send(CmdNop, 5'd0, 32'd0);
    drain();

    // 6: reset during stepping drops the response and clears breakpoints; counter wrap
    do_reset();
    expect_rsp("t6_setbp", 1'b0, 32'd0);
    send(CmdSetBp, 5'd0, 32'h8);
    send(CmdStep, 5'd0, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_b("t6_halted", halted, 1'b1);
    check_b("t6_no_rsp", rsp_valid, 1'b0);
    check("t6_cause", 32'(halt_cause), 32'(CauseCmd));
    check_b("t6_ready", cmd_ready, 1'b1);
    expect_rsp("t6_run", 1'b0, 32'd0);
    send(CmdRun, 5'd0, 32'd0);
    n = 0;
    while (pc < 32'h10 && !halted && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_b("t6_bp_cleared", halted, 1'b0);
    expect_rsp("t6_halt", 1'b0, 32'd0);
    send(CmdHalt, 5'd0, 32'd0);
    drain();
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cycle_cnt_q;
    expect_rsp("t6_run2", 1'b0, 32'd0);
    send(CmdRun, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    expect_rsp("t6_halt2", 1'b0, 32'd0);
    send(CmdHalt, 5'd0, 32'd0);
    expect_rsp("t6_cnt_wrap", 1'b0, 32'd1);
    send(CmdReadCnt, 5'd0, 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion within 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
